// File: rtl/avalon_mem_responder_pkg.sv
// Shared types and constants for the Avalon-MM memory responder.
// Holds the FSM state encoding and the stall-count limit.
package avalon_mem_responder_pkg;

  typedef enum logic [0:0] {AVL_IDLE, AVL_STALL} avl_state_t;

  localparam int unsigned AVL_MAX_WAIT = 15;
  localparam int unsigned AVL_CNT_W    = 4;

  function automatic logic [31:0] avl_offset(input logic [31:0] addr, input logic [31:0] base);
    return addr - base;
  endfunction

endpackage

// File: rtl/avalon_req_checker.sv
// Captures the request fields when a transfer starts stalling and flags any change
// to them (or a simultaneous read and write) as a single-cycle violation.
module avalon_req_checker
  import avalon_mem_responder_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_in_stall,
  input  logic [31:0] i_address,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [31:0] i_writedata,
  input  logic [3:0]  i_byteenable,
  output logic        o_viol
);

  logic [31:0] r_address;
  logic        r_read;
  logic        r_write;
  logic [31:0] r_writedata;
  logic [3:0]  r_byteenable;
  logic        w_mismatch;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_address    <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_writedata  <= '0;
      r_byteenable <= '0;
    end else if (i_start) begin
      r_address    <= i_address;
      r_read       <= i_read;
      r_write      <= i_write;
      r_writedata  <= i_writedata;
      r_byteenable <= i_byteenable;
    end
  end

  // A dropped request shows up here as read/write differing from the latched copy.
  always_comb begin
    w_mismatch = i_in_stall &&
                 ({i_address, i_read, i_write, i_writedata, i_byteenable} !=
                  {r_address, r_read, r_write, r_writedata, r_byteenable});
    o_viol     = (i_read & i_write) | w_mismatch;
  end

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave memory model: word reads, byte-enabled writes, programmable
// waitrequest stalls, sticky protocol-error flag and a completed-transfer counter.
module avalon_mem_responder
  import avalon_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [31:0] i_writedata,
  input  logic [3:0]  i_byteenable,
  output logic        o_waitrequest,
  output logic [31:0] o_readdata,
  output logic        o_err,
  output logic [31:0] o_xfer_count
);

  localparam int unsigned          IdxW    = $clog2(DEPTH_WORDS);
  localparam logic [AVL_CNT_W-1:0] WaitCnt = AVL_CNT_W'(WAIT_CYCLES);

  avl_state_t           r_state, w_state_d;
  logic [AVL_CNT_W-1:0] r_cnt, w_cnt_d;
  logic [31:0]          r_readdata;
  logic [31:0]          r_xfer_count;
  logic                 r_err;
  logic [31:0]          r_mem [DEPTH_WORDS];

  logic                 w_req;
  logic                 w_complete;
  logic                 w_start;
  logic                 w_viol;
  logic [31:0]          w_offset;
  logic                 w_addr_bad;
  logic [IdxW-1:0]      w_idx;

  always_comb begin
    w_req         = i_read | i_write;
    w_offset      = avl_offset(i_address, BASE_ADDR);
    w_addr_bad    = (w_offset[1:0] != 2'b00) || (w_offset[31:2] >= 30'(DEPTH_WORDS));
    w_idx         = w_offset[IdxW+1:2];
    // In IDLE the counter is 0, so a zero-wait build completes in the request cycle.
    w_complete    = i_reset && w_req && (r_cnt == WaitCnt);
    o_waitrequest = !i_reset || (w_req && (r_cnt != WaitCnt));
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_start   = 1'b0;
    unique case (r_state)
      AVL_IDLE: begin
        if (w_req && (WaitCnt != '0)) begin
          w_start   = 1'b1;
          w_state_d = AVL_STALL;
          w_cnt_d   = AVL_CNT_W'(1);
        end
      end
      AVL_STALL: begin
        if (!w_req || w_complete) begin
          w_state_d = AVL_IDLE;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + AVL_CNT_W'(1);
        end
      end
      default: begin
        w_state_d = AVL_IDLE;
        w_cnt_d   = '0;
      end
    endcase
  end

  avalon_req_checker u_checker (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_start      (w_start),
    .i_in_stall   (r_state == AVL_STALL),
    .i_address    (i_address),
    .i_read       (i_read),
    .i_write      (i_write),
    .i_writedata  (i_writedata),
    .i_byteenable (i_byteenable),
    .o_viol       (w_viol)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= AVL_IDLE;
      r_cnt        <= '0;
      r_readdata   <= '0;
      r_xfer_count <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_complete) begin
        r_xfer_count <= r_xfer_count + 32'd1;
        if (i_read) begin
          r_readdata <= w_addr_bad ? 32'h0 : r_mem[w_idx];
        end
      end
      if (w_viol || (w_complete && w_addr_bad)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge i_clk) begin
    if (w_complete && i_write && !i_read && !w_addr_bad) begin
      for (int b = 0; b < 4; b++) begin
        if (i_byteenable[b]) begin
          r_mem[w_idx][8*b +: 8] <= i_writedata[8*b +: 8];
        end
      end
    end
  end

  assign o_readdata   = r_readdata;
  assign o_err        = r_err;
  assign o_xfer_count = r_xfer_count;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed bench: a WAIT_CYCLES=2 instance for stall/error/reset scenarios and a
// WAIT_CYCLES=0 instance for back-to-back streaming.
module tb_avalon_mem_responder;

  localparam logic [31:0] Base = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a_address = '0, a_wdata = '0, a_rdata, a_cnt;
  logic        a_read = 1'b0, a_write = 1'b0, a_wait, a_err;
  logic [3:0]  a_be = '0;
  logic [31:0] b_address = '0, b_wdata = '0, b_rdata, b_cnt;
  logic        b_read = 1'b0, b_write = 1'b0, b_wait, b_err;
  logic [3:0]  b_be = '0;

  int n_cmp = 0;
  int n_bad = 0;

  avalon_mem_responder #(.BASE_ADDR(Base), .DEPTH_WORDS(1024), .WAIT_CYCLES(2), .INIT_FILE(""))
  u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_address(a_address), .i_read(a_read), .i_write(a_write),
    .i_writedata(a_wdata), .i_byteenable(a_be), .o_waitrequest(a_wait), .o_readdata(a_rdata),
    .o_err(a_err), .o_xfer_count(a_cnt)
  );

  avalon_mem_responder #(.BASE_ADDR(Base), .DEPTH_WORDS(1024), .WAIT_CYCLES(0), .INIT_FILE(""))
  u_dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_address(b_address), .i_read(b_read), .i_write(b_write),
    .i_writedata(b_wdata), .i_byteenable(b_be), .o_waitrequest(b_wait), .o_readdata(b_rdata),
    .o_err(b_err), .o_xfer_count(b_cnt)
  );

  // Called at posedge+1; returns at posedge+1 after the completion edge with the request dropped.
  task automatic xfer_a(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be,
                        output int waits, output logic done);
    a_address = addr; a_read = rd; a_write = wr; a_wdata = data; a_be = be;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (a_wait === 1'b0) done = 1'b1;
      else waits++;
      @(posedge clk); #1;
    end
    a_read = 1'b0; a_write = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    n_cmp++; if (a_wait !== 1'b1) begin n_bad++; $display("FAIL reset_wait: got %b want 1", a_wait); end
    n_cmp++; if (b_wait !== 1'b1) begin n_bad++; $display("FAIL reset_wait0: got %b want 1", b_wait); end
    n_cmp++; if (a_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", a_rdata); end
    n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", a_err); end
    n_cmp++; if (a_cnt !== 32'h0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", a_cnt); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (a_wait !== 1'b0) begin n_bad++; $display("FAIL idle_wait: got %b want 0", a_wait); end
  endtask

  task automatic test_read_stall();
    int w; logic d;
    xfer_a(1'b0, 1'b1, Base, 32'h1234_5678, 4'hF, w, d);
    n_cmp++; if (!d || w != 2) begin n_bad++; $display("FAIL wr_stall: got done=%b waits=%0d want 1/2", d, w); end
    xfer_a(1'b1, 1'b0, Base, 32'h0, 4'h0, w, d);
    n_cmp++; if (!d || w != 2) begin n_bad++; $display("FAIL rd_stall: got done=%b waits=%0d want 1/2", d, w); end
    n_cmp++; if (a_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_data: got %h want 12345678", a_rdata); end
    n_cmp++; if (a_cnt !== 32'd2) begin n_bad++; $display("FAIL rd_cnt: got %0d want 2", a_cnt); end
  endtask

  task automatic test_byte_write();
    int w; logic d;
    xfer_a(1'b0, 1'b1, Base + 32'hC, 32'h0, 4'hF, w, d);
    xfer_a(1'b0, 1'b1, Base + 32'hC, 32'hAABB_CCDD, 4'b0101, w, d);
    xfer_a(1'b1, 1'b0, Base + 32'hC, 32'h0, 4'h0, w, d);
    n_cmp++; if (a_rdata !== 32'h00BB_00DD) begin n_bad++; $display("FAIL be_data: got %h want 00BB00DD", a_rdata); end
    xfer_a(1'b0, 1'b1, Base + 32'hC, 32'hFFFF_FFFF, 4'h0, w, d);
    n_cmp++; if (!d || w != 2) begin n_bad++; $display("FAIL be0_stall: got done=%b waits=%0d want 1/2", d, w); end
    xfer_a(1'b1, 1'b0, Base + 32'hC, 32'h0, 4'h0, w, d);
    n_cmp++; if (a_rdata !== 32'h00BB_00DD) begin n_bad++; $display("FAIL be0_data: got %h want 00BB00DD", a_rdata); end
    n_cmp++; if (a_cnt !== 32'd7) begin n_bad++; $display("FAIL be_cnt: got %0d want 7", a_cnt); end
    n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL be_err: got %b want 0", a_err); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'hA0A0_0001; vals[1] = 32'hB1B1_0002; vals[2] = 32'hC2C2_0003;
    b_be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      b_write = 1'b1; b_address = Base + 32'(4 * i); b_wdata = vals[i];
      #1;
      n_cmp++; if (b_wait !== 1'b0) begin n_bad++; $display("FAIL b2b_wr_wait%0d: got %b want 0", i, b_wait); end
      @(posedge clk); #1;
    end
    b_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_read = (i < 3); b_address = Base + 32'(4 * i);
      #1;
      if (i < 3) begin
        n_cmp++; if (b_wait !== 1'b0) begin n_bad++; $display("FAIL b2b_rd_wait%0d: got %b want 0", i, b_wait); end
      end
      if (i > 0) begin
        n_cmp++;
        if (b_rdata !== vals[i-1]) begin
          n_bad++; $display("FAIL b2b_data%0d: got %h want %h", i - 1, b_rdata, vals[i-1]);
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (b_cnt !== 32'd6) begin n_bad++; $display("FAIL b2b_cnt: got %0d want 6", b_cnt); end
  endtask

  task automatic test_addr_err();
    int w; logic d;
    xfer_a(1'b1, 1'b0, Base + 32'h2, 32'h0, 4'h0, w, d);
    n_cmp++; if (!d || w != 2) begin n_bad++; $display("FAIL mis_stall: got done=%b waits=%0d want 1/2", d, w); end
    n_cmp++; if (a_rdata !== 32'h0) begin n_bad++; $display("FAIL mis_data: got %h want 0", a_rdata); end
    n_cmp++; if (a_err !== 1'b1) begin n_bad++; $display("FAIL mis_err: got %b want 1", a_err); end
    n_cmp++; if (a_cnt !== 32'd8) begin n_bad++; $display("FAIL mis_cnt: got %0d want 8", a_cnt); end
    xfer_a(1'b1, 1'b0, Base, 32'h0, 4'h0, w, d);
    n_cmp++; if (a_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL ok_data: got %h want 12345678", a_rdata); end
    xfer_a(1'b1, 1'b0, Base + 32'h1000, 32'h0, 4'h0, w, d);
    n_cmp++; if (a_rdata !== 32'h0) begin n_bad++; $display("FAIL oor_data: got %h want 0", a_rdata); end
    n_cmp++; if (a_cnt !== 32'd10) begin n_bad++; $display("FAIL oor_cnt: got %0d want 10", a_cnt); end
  endtask

  task automatic test_protocol();
    int w; logic d;
    apply_reset();
    n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", a_err); end
    n_cmp++; if (a_cnt !== 32'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", a_cnt); end
    a_read = 1'b1; a_address = Base;
    @(posedge clk); #1;
    xfer_a(1'b1, 1'b0, Base + 32'h4, 32'h0, 4'h0, w, d);
    n_cmp++; if (!d) begin n_bad++; $display("FAIL chg_done: got %b want 1", d); end
    n_cmp++; if (a_err !== 1'b1) begin n_bad++; $display("FAIL chg_err: got %b want 1", a_err); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (a_err !== 1'b1) begin n_bad++; $display("FAIL sticky_err: got %b want 1", a_err); end
    n_cmp++; if (a_cnt !== 32'd1) begin n_bad++; $display("FAIL chg_cnt: got %0d want 1", a_cnt); end
    a_read = 1'b1; a_address = Base;
    @(posedge clk); #1;
    a_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (a_cnt !== 32'd1) begin n_bad++; $display("FAIL drop_cnt: got %0d want 1", a_cnt); end
    apply_reset();
    n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL clr_err: got %b want 0", a_err); end
    xfer_a(1'b1, 1'b1, Base + 32'h10, 32'h0, 4'hF, w, d);
    n_cmp++; if (a_err !== 1'b1) begin n_bad++; $display("FAIL rw_err: got %b want 1", a_err); end
    apply_reset();
    n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL rw_clr: got %b want 0", a_err); end
  endtask

  task automatic test_reset_mid_stall();
    int w; logic d;
    xfer_a(1'b0, 1'b1, Base + 32'h14, 32'h1111_1111, 4'hF, w, d);
    a_write = 1'b1; a_address = Base + 32'h14; a_wdata = 32'h2222_2222; a_be = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_wait !== 1'b1) begin n_bad++; $display("FAIL mid_wait: got %b want 1", a_wait); end
    @(posedge clk); @(posedge clk); #1;
    a_write = 1'b0;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (a_cnt !== 32'd0) begin n_bad++; $display("FAIL mid_cnt: got %0d want 0", a_cnt); end
    n_cmp++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL mid_err: got %b want 0", a_err); end
    @(posedge clk); #1;
    xfer_a(1'b1, 1'b0, Base + 32'h14, 32'h0, 4'h0, w, d);
    n_cmp++; if (a_rdata !== 32'h1111_1111) begin n_bad++; $display("FAIL mid_data: got %h want 11111111", a_rdata); end
    n_cmp++; if (a_cnt !== 32'd1) begin n_bad++; $display("FAIL mid_cnt2: got %0d want 1", a_cnt); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_read_stall();
    test_byte_write();
    test_back_to_back();
    test_addr_err();
    test_protocol();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
